seq_mult_shift_add: RTL

- Parametrised sequential WIDTH x WIDTH unsigned multiplier.
- Uses a radix-2 shift-add algorithm. Each step is one pass through a single WIDTH-bit ripple-carry adder built from full-adder cells.
- Replaces the fixed 4x4 array multiplier wherever area matters more than latency.
- Uses a start/ready/done handshake towards the control logic.

---
 rtl/seq_mult_pkg.sv | 17 +
 rtl/seq_mult_shift_add_rca.sv | 31 +++
 rtl/seq_mult_shift_add.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// ----------------------------------------------------------------------------
// seq_mult_pkg
//   Shared definitions for the sequential shift-add multiplier:
//     state_e                 - FSM state encoding (IDLE/RUN/DONE)
//     SEQ_MULT_DEFAULT_WIDTH  - default operand width
// ----------------------------------------------------------------------------
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned SEQ_MULT_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/seq_mult_shift_add_rca.sv
// ----------------------------------------------------------------------------
// rca_nbit
//   N-bit ripple-carry adder built from a chain of full-adder cells.
//   Ports:
//     x, y  [N-1:0] in  addends
//     cin         in  carry into bit 0
//     sum   [N-1:0] out sum bits
//     cout        out carry out of bit N-1
// ----------------------------------------------------------------------------
module rca_nbit #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_mult_shift_add.sv
// ----------------------------------------------------------------------------
// seq_mult_shift_add
//   Sequential WIDTH x WIDTH multiplier, radix-2 shift-add, one ripple-carry
//   adder pass per step. A product takes WIDTH RUN cycles plus one DONE cycle.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset
//     start    in   request, accepted only while ready=1
//     a, b     in   multiplicand / multiplier, sampled on the accepting edge
//     ready    out  idle, can accept start
//     busy     out  multiplication in progress
//     done     out  one-cycle pulse when product is newly updated
//     product  out  2*WIDTH-bit result, held until the next completion
//   Build option:
//     SEQ_MULT_SIGNED_EN - operands and product are two's complement
//                          (WIDTH+1-bit adder, arithmetic shift, final-step
//                          subtract). Undefined: unsigned.
// ----------------------------------------------------------------------------
module seq_mult_shift_add
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  // Upper half of the accumulator after the add, one bit wider than WIDTH;
  // it becomes the new top of acc after the right shift.
  logic [WIDTH:0]       step_hi;

`ifdef SEQ_MULT_SIGNED_EN
  logic [WIDTH:0] add_x;
  logic [WIDTH:0] add_y;
  logic [WIDTH:0] add_s;
  logic           add_ci;
  logic           add_co_unused;

  // Last multiplier bit carries negative weight: subtract mcand on that step.
  always_comb begin
    add_x  = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
    add_y  = '0;
    add_ci = 1'b0;
    if (acc_q[0]) begin
      if (cnt_q == LAST_STEP) begin
        add_y  = ~{mcand_q[WIDTH-1], mcand_q};
        add_ci = 1'b1;
      end else begin
        add_y  = {mcand_q[WIDTH-1], mcand_q};
      end
    end
  end

  rca_nbit #(.N(WIDTH + 1)) u_rca (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co_unused)
  );

  assign step_hi = add_s;
`else
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_s;
  logic             add_co;

  assign add_y = acc_q[0] ? mcand_q : '0;

  rca_nbit #(.N(WIDTH)) u_rca (
    .x    (acc_q[2*WIDTH-1:WIDTH]),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_co)
  );

  assign step_hi = {add_co, add_s};
`endif

  assign acc_d = {step_hi, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
            state_q <= S_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            product_q <= acc_d;
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
